// File: rtl/mul4_sched_pkg.sv
// Shared types and constants for the bit-sliced 2x2 multiplier evaluation scheduler.
// Holds the FSM state enum, the base/golden vectors and the per-pass rotation helper.
package mul4_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SAMPLE,
    S_ACC,
    S_DONE
  } state_e;

  localparam int IDX_W   = 3;
  localparam int SCORE_W = 9;

  // Column i of the operand vectors encodes a = i[3:2], b = i[1:0]; golden is a*b per column.
  localparam logic [15:0] A1_BASE = 16'hFF00;
  localparam logic [15:0] A0_BASE = 16'hF0F0;
  localparam logic [15:0] B1_BASE = 16'hCCCC;
  localparam logic [15:0] B0_BASE = 16'hAAAA;
  localparam logic [15:0] Y3_GOLD = 16'h8000;
  localparam logic [15:0] Y2_GOLD = 16'h4C00;
  localparam logic [15:0] Y1_GOLD = 16'h6AC0;
  localparam logic [15:0] Y0_GOLD = 16'hA0A0;

  function automatic logic [15:0] rotl4k(input logic [15:0] v, input logic [1:0] k);
    logic [31:0] t;
    t = {v, v} << {k, 2'b00};
    return t[31:16];
  endfunction

endpackage

// File: rtl/mul4_rr_arb.sv
// Round-robin arbiter: picks the first requester at or after the pointer, wrapping.
// The pointer moves past the winner whenever the caller takes the grant.
module mul4_rr_arb
  import mul4_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req_i,
  input  logic             take_i,
  output logic             any_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;

  // Scan farthest offset first so the nearest requester overwrites and wins.
  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      int c;
      c = (int'(ptr_q) + off) % NREQ;
      if (req_i[c]) begin
        any_o = 1'b1;
        idx_o = IDX_W'(c);
      end
    end
  end

  always_comb begin
    int nxt;
    nxt   = (int'(idx_o) + 1) % NREQ;
    ptr_d = ptr_q;
    if (take_i && any_o) ptr_d = IDX_W'(nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mul4_eval_sched.sv
// Shares one external 2x2 bit-sliced multiplier evaluator among NREQ requesters and
// scores each evaluation as the number of product bits matching golden over NPASS passes.
module mul4_eval_sched
  import mul4_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NPASS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  output logic [NREQ-1:0]    grant,
  output logic               busy,
  output logic [15:0]        a1,
  output logic [15:0]        a0,
  output logic [15:0]        b1,
  output logic [15:0]        b0,
  input  logic [15:0]        y3,
  input  logic [15:0]        y2,
  input  logic [15:0]        y1,
  input  logic [15:0]        y0,
  output logic               done,
  output logic [2:0]         done_id,
  output logic [SCORE_W-1:0] score
);

  state_e               state_q, state_d;
  logic [NREQ-1:0]      grant_q, grant_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [1:0]           k_q, k_d;
  logic [SCORE_W-1:0]   acc_q, acc_d, score_q, score_d;
  logic [2:0]           done_id_q, done_id_d;
  logic [15:0]          a1_q, a0_q, b1_q, b0_q, a1_d, a0_d, b1_d, b0_d;
  logic [63:0]          ys_q, gs_q;
  logic                 arb_any;
  logic [IDX_W-1:0]     arb_idx;
  logic [6:0]           pc;

  mul4_rr_arb #(.NREQ(NREQ)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req_i  (req),
    .take_i (state_q == S_IDLE),
    .any_o  (arb_any),
    .idx_o  (arb_idx)
  );

  always_comb begin
    logic [63:0] match;
    match = ~(ys_q ^ gs_q);
    pc    = '0;
    for (int i = 0; i < 64; i++) pc = pc + {6'd0, match[i]};
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    k_d       = k_q;
    acc_d     = acc_q;
    score_d   = score_q;
    done_id_d = done_id_q;
    a1_d      = a1_q;
    a0_d      = a0_q;
    b1_d      = b1_q;
    b0_d      = b0_q;
    case (state_q)
      S_IDLE: begin
        if (arb_any) begin
          grant_d = {{(NREQ-1){1'b0}}, 1'b1} << arb_idx;
          idx_d   = arb_idx;
          acc_d   = '0;
          k_d     = '0;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        a1_d    = rotl4k(A1_BASE, k_q);
        a0_d    = rotl4k(A0_BASE, k_q);
        b1_d    = rotl4k(B1_BASE, k_q);
        b0_d    = rotl4k(B0_BASE, k_q);
        state_d = S_SAMPLE;
      end
      S_SAMPLE: state_d = S_ACC;
      S_ACC: begin
        acc_d = acc_q + SCORE_W'(pc);
        if (k_q == 2'(NPASS - 1)) begin
          score_d   = acc_q + SCORE_W'(pc);
          done_id_d = 3'(idx_q);
          a1_d      = '0;
          a0_d      = '0;
          b1_d      = '0;
          b0_d      = '0;
          state_d   = S_DONE;
        end else begin
          k_d     = k_q + 2'd1;
          state_d = S_DRIVE;
        end
      end
      S_DONE: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      idx_q     <= '0;
      k_q       <= '0;
      acc_q     <= '0;
      score_q   <= '0;
      done_id_q <= '0;
      a1_q      <= '0;
      a0_q      <= '0;
      b1_q      <= '0;
      b0_q      <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      score_q   <= score_d;
      done_id_q <= done_id_d;
      a1_q      <= a1_d;
      a0_q      <= a0_d;
      b1_q      <= b1_d;
      b0_q      <= b0_d;
    end
  end

  // Evaluator response and the matching golden pass are captured together in SAMPLE.
  always_ff @(posedge clk) begin
    if (state_q == S_SAMPLE) begin
      ys_q <= {y3, y2, y1, y0};
      gs_q <= {rotl4k(Y3_GOLD, k_q), rotl4k(Y2_GOLD, k_q),
               rotl4k(Y1_GOLD, k_q), rotl4k(Y0_GOLD, k_q)};
    end
  end

  assign grant   = grant_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign done_id = done_id_q;
  assign score   = score_q;
  assign a1      = a1_q;
  assign a0      = a0_q;
  assign b1      = b1_q;
  assign b0      = b0_q;

endmodule

// File: tb/tb_mul4_eval_sched.sv
// Bench for mul4_eval_sched: table of evaluator behaviours, arbitration sequences,
// reset abort, randomized faulty evaluators, and a single-pass instance.
module tb_mul4_eval_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  req, req1;
  logic [3:0]  grant, grant1;
  logic        busy, busy1, done, done1;
  logic [15:0] a1, a0, b1, b0, y3, y2, y1, y0;
  logic [15:0] a1_1, a0_1, b1_1, b0_1, y3_1, y2_1, y1_1, y0_1;
  logic [2:0]  done_id, done_id1;
  logic [8:0]  score, score1;

  int          mode;
  logic [63:0] fmask;
  logic [63:0] ideal0, yv;
  int          n_chk = 0;
  int          n_fail = 0;
  int          mdl_ptr = 0;

  mul4_eval_sched #(.NREQ(4), .NPASS(4)) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant), .busy(busy),
    .a1(a1), .a0(a0), .b1(b1), .b0(b0), .y3(y3), .y2(y2), .y1(y1), .y0(y0),
    .done(done), .done_id(done_id), .score(score)
  );

  mul4_eval_sched #(.NREQ(4), .NPASS(1)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .grant(grant1), .busy(busy1),
    .a1(a1_1), .a0(a0_1), .b1(b1_1), .b0(b0_1),
    .y3(y3_1), .y2(y2_1), .y1(y1_1), .y0(y0_1),
    .done(done1), .done_id(done_id1), .score(score1)
  );

  // Ideal evaluator: each column multiplies the 2-bit a by the 2-bit b.
  function automatic logic [63:0] ideal_eval(input logic [15:0] xa1, xa0, xb1, xb0);
    logic [15:0] p3, p2, p1, p0;
    for (int i = 0; i < 16; i++) begin
      int av, bv, p;
      av = int'({xa1[i], xa0[i]});
      bv = int'({xb1[i], xb0[i]});
      p  = av * bv;
      p3[i] = p[3]; p2[i] = p[2]; p1[i] = p[1]; p0[i] = p[0];
    end
    return {p3, p2, p1, p0};
  endfunction

  always_comb begin
    ideal0 = ideal_eval(a1, a0, b1, b0);
    case (mode)
      0:       yv = ideal0 ^ fmask;
      1:       yv = '0;
      2:       yv = '1;
      default: yv = ~ideal0;
    endcase
  end
  assign {y3, y2, y1, y0} = yv;
  assign {y3_1, y2_1, y1_1, y0_1} = ideal_eval(a1_1, a0_1, b1_1, b0_1);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; req1 = '0; mode = 0; fmask = '0;
    tick(); tick();
    rst = 1'b0;
    mdl_ptr = 0;
  endtask

  // One evaluation on the NPASS=4 instance, req held until done.
  task automatic run_eval(input logic [3:0] r, input int md, input logic [63:0] mk,
                          input int eid, input int esc);
    int lat;
    lat = 0;
    req = r; mode = md; fmask = mk;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 1) begin
        chk("grant_onehot", 64'(grant), 64'(4'b0001 << eid));
        chk("busy_at_grant", 64'(busy), 64'd1);
        chk("ops_zero_drive0", 64'({a1, a0, b1, b0}), 64'd0);
      end
      if (c == 5) chk("a1_pass1_rot", 64'(a1), 64'h0000_F00F);
      if (c == 8) chk("a1_pass2_rot", 64'(a1), 64'h0000_00FF);
      if (done) begin
        lat = c;
        break;
      end
    end
    chk("latency", 64'(lat), 64'd13);
    chk("done_id", 64'(done_id), 64'(eid));
    chk("score", 64'(score), 64'(esc));
    chk("ops_zero_done", 64'({a1, a0, b1, b0}), 64'd0);
    req = '0;
    tick();
    chk("done_one_cycle", 64'({done, grant}), 64'd0);
    mdl_ptr = (eid + 1) % 4;
  endtask

  typedef struct {
    logic [3:0]  r;
    int          md;
    logic [63:0] mk;
    int          id;
    int          sc;
  } vec_t;
  vec_t tbl[8];

  initial begin
    int dn, last_t, ids[5], ts[5];
    tbl[0] = '{4'b0001, 0, 64'h0,   0, 256};
    tbl[1] = '{4'b0001, 1, 64'h0,   0, 200};
    tbl[2] = '{4'b0001, 2, 64'h0,   0, 56};
    tbl[3] = '{4'b0001, 3, 64'h0,   0, 0};
    tbl[4] = '{4'b1000, 0, 64'h1,   3, 252};
    tbl[5] = '{4'b0110, 0, 64'hFF,  1, 224};
    tbl[6] = '{4'b0110, 0, 64'h0,   2, 256};
    tbl[7] = '{4'b1001, 0, 64'h0,   3, 256};

    do_reset();
    chk("rst_outputs", 64'({grant, busy, done, done_id, score}), 64'd0);
    chk("rst_operands", 64'({a1, a0, b1, b0}), 64'd0);

    for (int i = 0; i < 8; i++)
      run_eval(tbl[i].r, tbl[i].md, tbl[i].mk, tbl[i].id, tbl[i].sc);

    // All four requesting continuously: fair rotation with one idle cycle between.
    do_reset();
    req = 4'b1111;
    dn = 0;
    for (int c = 1; c <= 80 && dn < 5; c++) begin
      tick();
      if (done) begin
        ids[dn] = int'(done_id);
        ts[dn] = c;
        chk("grant_in_done", 64'(grant), 64'(4'b0001 << (dn % 4)));
        dn++;
      end
    end
    req = '0;
    chk("rr_done_count", 64'(dn), 64'd5);
    for (int i = 0; i < 5 && i < dn; i++) chk("rr_id_seq", 64'(ids[i]), 64'(i % 4));
    for (int i = 1; i < 5 && i < dn; i++) chk("rr_period", 64'(ts[i] - ts[i-1]), 64'd14);

    // Single-cycle request pulse still completes exactly once.
    do_reset();
    req = 4'b0010;
    tick();
    req = '0;
    dn = 0;
    for (int c = 0; c < 30; c++) begin
      if (done) dn++;
      tick();
    end
    chk("pulse_done_count", 64'(dn), 64'd1);
    chk("pulse_id_held", 64'(done_id), 64'd1);
    chk("pulse_score_held", 64'(score), 64'd256);

    // Reset in the middle of an evaluation abandons it.
    do_reset();
    req = 4'b0001;
    for (int c = 0; c < 6; c++) tick();
    chk("mid_busy", 64'(busy), 64'd1);
    rst = 1'b1; req = '0;
    tick();
    rst = 1'b0;
    mdl_ptr = 0;
    chk("abort_outputs", 64'({grant, busy, done, done_id, score}), 64'd0);
    chk("abort_operands", 64'({a1, a0, b1, b0}), 64'd0);
    dn = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) dn++;
      tick();
    end
    chk("abort_no_done", 64'(dn), 64'd0);
    run_eval(4'b0100, 0, 64'h0, 2, 256);

    // Randomized requests and faulty evaluators against the arbitration/score model.
    do_reset();
    for (int n = 0; n < 12; n++) begin
      logic [3:0]  r;
      logic [63:0] mk;
      int          eid;
      bit          found;
      r = 4'($urandom_range(1, 15));
      mk = {32'($urandom), 32'($urandom)};
      if (n % 3 == 0) mk = '0;
      eid = 0; found = 0;
      for (int o = 0; o < 4; o++) begin
        int c;
        c = (mdl_ptr + o) % 4;
        if (!found && r[c]) begin
          eid = c;
          found = 1;
        end
      end
      run_eval(r, 0, mk, eid, 4 * (64 - $countones(mk)));
    end

    // Single-pass instance: unrotated operands, score 64 after 4 cycles.
    do_reset();
    req1 = 4'b0001;
    last_t = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 2) chk("np1_ops", 64'({a1_1, a0_1, b1_1, b0_1}), 64'hFF00_F0F0_CCCC_AAAA);
      if (done1) begin
        last_t = c;
        break;
      end
    end
    req1 = '0;
    chk("np1_latency", 64'(last_t), 64'd4);
    chk("np1_score", 64'(score1), 64'd64);
    chk("np1_done_id", 64'(done_id1), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mul4_eval_sched.md
MUL4_EVAL_SCHED -- requirements
Module: mul4_eval_sched

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the evaluator (2..8).
REQ-002 Parameter NPASS, default 4, number of rotated test passes per evaluation (1..4).
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 req  in  NREQ  per-requester evaluation request, level.
REQ-007 grant  out  NREQ  one-hot owner of current evaluation, else 0.
REQ-008 busy  out  1  evaluation in progress.
REQ-009 a1, a0, b1, b0  out  16 each  registered operand vectors to the shared combinational 2x2-bit bit-sliced multiplier under test.
REQ-010 y3, y2, y1, y0  in  16 each  product vectors returned by the evaluator, same cycle.
REQ-011 done  out  1  one-cycle pulse, result valid.
REQ-012 done_id  out  3  index of the requester whose result is on score.
REQ-013 score  out  9  matching-bit count, 0..64*NPASS.

Function
REQ-014 FSM states: IDLE, DRIVE, SAMPLE, ACC, DONE.
REQ-015 IDLE: if any req bit set, grant the first set bit at or after rr_ptr (round-robin, wrapping), latch its index, clear the accumulator and pass counter, go to DRIVE; else stay.
REQ-016 rr_ptr shall advance to granted index+1 (mod NREQ) on each grant.
REQ-017 DRIVE: register operands for pass k as base vectors a1=FF00, a0=F0F0, b1=CCCC, b0=AAAA, each rotated left by 4*k bits; go to SAMPLE.
REQ-018 SAMPLE: register y3..y0 and the golden vectors (Y3=8000, Y2=4C00, Y1=6AC0, Y0=A0A0, rotated left by 4*k); go to ACC.
REQ-019 ACC: add popcount of XNOR over all 64 sampled bits to the accumulator; if k==NPASS-1 go to DONE, else k++ and go to DRIVE.
REQ-020 DONE: assert done for exactly one cycle with score=accumulator and done_id=latched index; return to IDLE.
REQ-021 Latency from grant cycle to done cycle shall be exactly 3*NPASS+1 cycles; score width shall never overflow (max 256).
REQ-022 grant and busy shall stay constant from the grant cycle through the DONE cycle; deasserting req mid-evaluation shall not abort it.
REQ-023 a1..b0 shall be 0 in IDLE and DONE, and hold their DRIVE values through SAMPLE and ACC.
REQ-024 A requester still requesting after DONE is re-arbitrated normally and receives lowest priority.
REQ-025 No new grant shall be issued in the DONE cycle; back-to-back evaluations are separated by one IDLE cycle.
REQ-026 score and done_id shall hold their last value between done pulses.

Reset
REQ-027 On rst: state=IDLE, grant=0, busy=0, done=0, done_id=0, score=0, operands=0, rr_ptr=0, accumulator=0, pass counter=0.
REQ-028 rst asserted mid-evaluation shall abandon it with no done pulse; the first grant after reset favours requester 0.

Structure
REQ-029 Shared package mul4_sched_pkg holds the FSM state enum, the eight base/golden vector constants and the rotate-by-4k function.
REQ-030 One sub-module, mul4_rr_arb (round-robin arbiter, NREQ-wide, with pointer register), is instantiated; popcount stays inline.

Verification
REQ-031 Evaluator is an ideal 2x2 multiplier, req=0001 -> grant=0001, done after 13 cycles, score=256, done_id=0.
REQ-032 Evaluator outputs tied to 0 -> score=200; all ones -> score=56; bitwise inverse of ideal -> score=0.
REQ-033 req=1111 held continuously -> done_id sequence 0,1,2,3,0; each grant lasts 13 cycles; 1 IDLE cycle between evaluations.
REQ-034 req pulse 1 cycle only -> evaluation runs to completion, done asserted once.
REQ-035 rst asserted at cycle 6 of an evaluation -> no done pulse; all outputs 0 next cycle; next req=0100 granted normally.
REQ-036 NPASS=1, ideal evaluator -> score=64 after 4 cycles; operands never rotated.
